// File: rtl/mnist_pkg.sv
// Constants and types shared by the frame loader, the image RAM and the DNN.
package mnist_pkg;

    localparam int         N_PIXELS  = 784;
    localparam int         ADDR_W    = $clog2(N_PIXELS);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        HUNT,
        LOAD,
        CHECK,
        HOLD
    } loader_state_e;

endpackage

// File: rtl/uart_frame_loader_idle_timeout.sv
// Idle-cycle counter: counts enabled clocks since the last clear and flags
// the terminal count TIMEOUT_CYC-1, where it saturates.
module idle_timeout #(
    parameter int  TIMEOUT_CYC = 1_000_000,
    localparam int CNT_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == TERMINAL);

    // NOTE: assigning the default first means every path writes cnt_d, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Sequences the UART byte stream into the image buffer: sync hunt, pixel
// load, checksum check, then holds the frame until the consumer acks it.
module uart_frame_loader
    import mnist_pkg::*;
#(
    parameter int         N_PIXELS    = mnist_pkg::N_PIXELS,
    parameter logic [7:0] SYNC_BYTE   = mnist_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         ADDR_W      = $clog2(N_PIXELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              err_chk,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        sum_q;
    logic [7:0]        sum_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              frame_valid_q;
    logic              err_chk_q;
    logic              err_timeout_q;
    logic              err_overrun_q;
    logic              in_frame;
    logic              idle_expired;

    assign sum_d    = sum_q + rx_byte;
    assign in_frame = (state_q == LOAD) || (state_q == CHECK);

    // Clearing outside LOAD/CHECK makes every entry into LOAD start from zero.
    idle_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid || !in_frame),
        .en     (in_frame),
        .expired(idle_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            addr_q        <= '0;
            sum_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_valid_q <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                        state_q <= LOAD;
                        addr_q  <= '0;
                        sum_q   <= '0;
                    end
                end
                LOAD: begin
                    // A byte arriving on the terminal count wins over the timeout.
                    if (rx_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= rx_byte;
                        sum_q     <= sum_d;
                        if (addr_q == LAST_ADDR) begin
                            state_q <= CHECK;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end else if (idle_expired) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= HUNT;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_byte == sum_q) begin
                            frame_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= HUNT;
                        end
                    end else if (idle_expired) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= HUNT;
                    end
                end
                HOLD: begin
                    err_overrun_q <= rx_valid;
                    if (frame_ack) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_valid = frame_valid_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: directed scenarios plus random
// frames, compared every cycle against a frame-position reference model.
module tb_uart_frame_loader;

    localparam int         N       = 784;
    localparam int         AW      = $clog2(N);
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 64;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_valid;
    logic          frame_ack;
    logic          err_chk;
    logic          err_timeout;
    logic          err_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    int n_wr = 0;
    int n_chk = 0;
    int n_to = 0;
    int n_ov = 0;
    int n_fvrise = 0;

    logic [7:0] pix [N];

    uart_frame_loader #(
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .err_chk    (err_chk),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model. m_pos is the frame position: -1 hunting, 0..N-1 next
    // pixel index, N awaiting checksum, N+1 frame held for the consumer.
    int            m_pos  = -1;
    int            m_sum  = 0;
    int            m_idle = 0;
    logic          e_wr   = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [7:0]    e_data = '0;
    logic          e_fv   = 1'b0;
    logic          e_chk  = 1'b0;
    logic          e_to   = 1'b0;
    logic          e_ov   = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pos = -1; m_sum = 0; m_idle = 0;
                e_wr = 1'b0; e_addr = '0; e_data = '0;
                e_fv = 1'b0; e_chk = 1'b0; e_to = 1'b0; e_ov = 1'b0;
            end else begin
                e_wr = 1'b0; e_chk = 1'b0; e_to = 1'b0; e_ov = 1'b0;
                if (m_pos < 0) begin
                    if (rx_valid && rx_byte == SYNC) begin
                        m_pos = 0; m_sum = 0; m_idle = 0;
                    end
                end else if (m_pos <= N) begin
                    if (rx_valid) begin
                        m_idle = 0;
                        if (m_pos < N) begin
                            e_wr   = 1'b1;
                            e_addr = AW'(m_pos);
                            e_data = rx_byte;
                            m_sum  = (m_sum + int'(rx_byte)) % 256;
                            m_pos++;
                        end else if (int'(rx_byte) == m_sum) begin
                            e_fv  = 1'b1;
                            m_pos = N + 1;
                        end else begin
                            e_chk = 1'b1;
                            m_pos = -1;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TIMEOUT) begin
                            e_to  = 1'b1;
                            m_pos = -1;
                        end
                    end
                end else begin
                    e_ov = rx_valid;
                    if (frame_ack) begin
                        e_fv  = 1'b0;
                        m_pos = -1;
                    end
                end
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    initial begin
        logic fv_prev;
        fv_prev = 1'b0;
        forever begin
            @(negedge clk);
            check("flags{wr,fv,chk,to,ov}",
                  32'({wr_en, frame_valid, err_chk, err_timeout, err_overrun}),
                  32'({e_wr, e_fv, e_chk, e_to, e_ov}));
            if (e_wr) begin
                check("wr_addr", 32'(wr_addr), 32'(e_addr));
                check("wr_data", 32'(wr_data), 32'(e_data));
            end
            if (wr_en === 1'b1) n_wr++;
            if (err_chk === 1'b1) n_chk++;
            if (err_timeout === 1'b1) n_to++;
            if (err_overrun === 1'b1) n_ov++;
            if (frame_valid === 1'b1 && !fv_prev) n_fvrise++;
            fv_prev = (frame_valid === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic ack);
        rx_valid  = v;
        rx_byte   = b;
        frame_ack = ack;
        tick();
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n, input bit noisy);
        repeat (n) drive(1'b0, 8'($urandom), noisy ? 1'($urandom_range(7) == 0) : 1'b0);
    endtask

    task automatic fill_pix(input bit rnd);
        for (int i = 0; i < N; i++) begin
            if (!rnd) pix[i] = 8'(i % 256);
            else if ($urandom_range(15) == 0) pix[i] = SYNC;
            else pix[i] = 8'($urandom);
        end
    endtask

    function automatic logic [7:0] frame_sum();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(pix[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_pixels(input int lo, input int hi, input int gap_max, input bit noisy);
        for (int i = lo; i < hi; i++) begin
            send(pix[i]);
            if (gap_max > 0) idle(int'($urandom_range(gap_max)), noisy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'(0));
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
        check({tag, "_wr_data"}, 32'(wr_data), 32'(0));
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'(0));
        check({tag, "_err_chk"}, 32'(err_chk), 32'(0));
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'(0));
        check({tag, "_err_overrun"}, 32'(err_overrun), 32'(0));
    endtask

    task automatic ack_frame(input string tag);
        drive(1'b0, 8'h00, 1'b1);
        check({tag, "_fv_fall"}, 32'(frame_valid), 32'(0));
    endtask

    initial begin
        int base_wr, base_chk, base_to, base_ov, base_rise;
        logic [7:0] b;
        bit bad;

        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; frame_ack = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Good frame, bytes back to back; the checksum of (i mod 256) is F8.
        fill_pix(1'b0);
        base_wr = n_wr;
        send(SYNC);
        send_pixels(0, N, 0, 1'b0);
        check("good_fv_before_sum", 32'(frame_valid), 32'(0));
        send(8'hF8);
        check("good_fv_rise", 32'(frame_valid), 32'(1));
        idle(3, 1'b0);
        check("good_fv_hold", 32'(frame_valid), 32'(1));
        check("good_write_count", 32'(n_wr - base_wr), 32'(N));
        ack_frame("good");

        // Bad checksum, then a random good frame.
        base_chk = n_chk; base_rise = n_fvrise;
        send(SYNC);
        send_pixels(0, N, 2, 1'b1);
        send(8'hF9);
        check("bad_err_chk", 32'(err_chk), 32'(1));
        check("bad_fv", 32'(frame_valid), 32'(0));
        idle(2, 1'b0);
        check("bad_err_chk_count", 32'(n_chk - base_chk), 32'(1));
        check("bad_no_fv", 32'(n_fvrise - base_rise), 32'(0));
        fill_pix(1'b1);
        send(SYNC);
        send_pixels(0, N, 3, 1'b1);
        send(frame_sum());
        check("after_bad_fv", 32'(frame_valid), 32'(1));
        ack_frame("after_bad");

        // Hunt filtering.
        fill_pix(1'b1);
        base_wr = n_wr;
        send(8'h00); send(8'hFF); send(8'h5A); send(SYNC);
        idle(1, 1'b0);
        check("hunt_no_write", 32'(n_wr - base_wr), 32'(0));
        send(pix[0]);
        check("hunt_first_wr_en", 32'(wr_en), 32'(1));
        check("hunt_first_addr", 32'(wr_addr), 32'(0));
        check("hunt_first_data", 32'(wr_data), 32'(pix[0]));
        send_pixels(1, N, 1, 1'b0);
        send(frame_sum());
        check("hunt_fv", 32'(frame_valid), 32'(1));
        ack_frame("hunt");

        // Timeout in LOAD after 10 pixels.
        fill_pix(1'b1);
        base_to = n_to;
        send(SYNC);
        send_pixels(0, 10, 0, 1'b0);
        idle(TIMEOUT - 1, 1'b0);
        check("to_before_terminal", 32'(err_timeout), 32'(0));
        idle(1, 1'b0);
        check("to_pulse", 32'(err_timeout), 32'(1));
        idle(1, 1'b0);
        check("to_single_pulse", 32'(err_timeout), 32'(0));
        check("to_count", 32'(n_to - base_to), 32'(1));
        send(8'h33);
        check("to_back_in_hunt", 32'(wr_en), 32'(0));

        // Byte exactly on the terminal count wins.
        send(SYNC);
        send_pixels(0, 5, 0, 1'b0);
        idle(TIMEOUT - 1, 1'b0);
        send(pix[5]);
        check("tc_byte_written", 32'(wr_en), 32'(1));
        check("tc_byte_addr", 32'(wr_addr), 32'(5));
        check("tc_no_timeout", 32'(err_timeout), 32'(0));
        idle(1, 1'b0);
        check("tc_no_timeout_late", 32'(err_timeout), 32'(0));
        send_pixels(6, N, 0, 1'b0);
        send(frame_sum());
        check("tc_fv", 32'(frame_valid), 32'(1));
        ack_frame("tc");

        // Timeout while waiting for the checksum.
        base_to = n_to;
        send(SYNC);
        send_pixels(0, N, 0, 1'b0);
        idle(TIMEOUT, 1'b0);
        check("to_check_pulse", 32'(err_timeout), 32'(1));
        idle(1, 1'b0);
        check("to_check_count", 32'(n_to - base_to), 32'(1));

        // Overrun in HOLD, second byte alongside the ack.
        fill_pix(1'b1);
        send(SYNC);
        send_pixels(0, N, 1, 1'b0);
        send(frame_sum());
        check("ov_fv", 32'(frame_valid), 32'(1));
        base_wr = n_wr; base_ov = n_ov;
        send(8'h11);
        check("ov_first", 32'(err_overrun), 32'(1));
        check("ov_fv_still", 32'(frame_valid), 32'(1));
        idle(1, 1'b0);
        drive(1'b1, 8'h22, 1'b1);
        check("ov_second", 32'(err_overrun), 32'(1));
        check("ov_fv_fall", 32'(frame_valid), 32'(0));
        idle(1, 1'b0);
        check("ov_count", 32'(n_ov - base_ov), 32'(2));
        check("ov_no_write", 32'(n_wr - base_wr), 32'(0));
        send(SYNC);
        send(pix[0]);
        check("ov_hunt_restart_addr", 32'(wr_addr), 32'(0));

        // Reset mid-LOAD after 100 pixels.
        send_pixels(1, 100, 0, 1'b0);
        check("rst_pre_wr_en", 32'(wr_en), 32'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        send(8'h5A);
        send(SYNC);
        send(pix[0]);
        check("rst_fresh_wr_en", 32'(wr_en), 32'(1));
        check("rst_fresh_addr", 32'(wr_addr), 32'(0));
        send_pixels(1, N, 1, 1'b1);
        send(frame_sum());
        check("rst_fresh_fv", 32'(frame_valid), 32'(1));
        ack_frame("rst_fresh");

        // Random frames with junk, gaps, stray acks, bad sums and overruns.
        for (int f = 0; f < 4; f++) begin
            fill_pix(1'b1);
            repeat (int'($urandom_range(3))) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                drive(1'b1, b, 1'($urandom_range(1)));
            end
            idle(int'($urandom_range(3)), 1'b1);
            send(SYNC);
            send_pixels(0, N, 3, 1'b1);
            bad = ($urandom_range(3) == 0);
            send(bad ? frame_sum() + 8'h01 : frame_sum());
            if (!bad) begin
                idle(int'($urandom_range(4)), 1'b0);
                if ($urandom_range(1) == 1) send(8'($urandom));
                idle(int'($urandom_range(2)), 1'b0);
                drive(1'b0, 8'h00, 1'b1);
            end
            idle(2, 1'b0);
        end

        idle(3, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
